// File: rtl/mult_pipe_pkg.sv
// Shared types and saturation helpers for the pipelined multiplier/MAC.
// Helpers work on a fixed maximum width so any parameter set fits.
package mult_pipe_pkg;

    localparam int MAX_W = 128;

    typedef logic [MAX_W-1:0] wide_t;

    typedef struct packed {
        logic signed_m;
        logic acc_en;
        logic acc_clr;
    } side_t;

    // Extend the low w bits of v to MAX_W, sign- or zero-filled.
    function automatic wide_t ext(input wide_t v, input int w, input logic sgn);
        wide_t hi_mask;
        hi_mask = ~wide_t'(0) << w;
        if (sgn && v[7'(w - 1)]) begin
            return v | hi_mask;
        end
        return v & ~hi_mask;
    endfunction

    function automatic wide_t sat_signed(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) << (w - 1)) - wide_t'(1);
        lo = ~hi;
        if ($signed(v) > $signed(hi)) begin
            return hi;
        end
        if ($signed(v) < $signed(lo)) begin
            return lo;
        end
        return v;
    endfunction

    function automatic wide_t sat_unsigned(input wide_t v, input int w);
        wide_t hi;
        hi = (wide_t'(1) << w) - wide_t'(1);
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/mult_pipe_round_sat.sv
// Round-half-up right shift of the final sum, then clip to the output width.
// Purely combinational; the extra bit keeps the rounding add from wrapping.
module mult_pipe_round_sat
    import mult_pipe_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int SHIFT = 0,
    parameter int OUT_W = 32
) (
    input  logic [ACC_W-1:0] sum,
    input  logic             signed_m,
    output logic [OUT_W-1:0] p,
    output logic             clip
);

    localparam int RW = ACC_W + 1;
    localparam int HS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [RW-1:0] HALF = (SHIFT > 0) ? (RW'(1) << HS) : '0;

    logic [RW-1:0]        sum_x;
    logic [RW-1:0]        biased;
    logic signed [RW-1:0] biased_s;
    logic [RW-1:0]        r;
    wide_t                r_ext;
    wide_t                sat;

    always_comb begin
        sum_x    = {signed_m & sum[ACC_W-1], sum};
        biased   = sum_x + HALF;
        biased_s = biased;
        if (signed_m) begin
            r = biased_s >>> SHIFT;
        end else begin
            r = biased >> SHIFT;
        end
        r_ext = ext(wide_t'(r), RW, signed_m);
        if (signed_m) begin
            sat = sat_signed(r_ext, OUT_W);
        end else begin
            sat = sat_unsigned(r_ext, OUT_W);
        end
        p    = sat[OUT_W-1:0];
        clip = (sat != r_ext);
    end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined multiplier/MAC with valid/ready flow control, per-beat sign mode,
// optional accumulation, rounding shift and output saturation.
module mult_pipe
    import mult_pipe_pkg::*;
#(
    parameter int WIDTH_A = 16,
    parameter int WIDTH_B = 16,
    parameter int ACC_W   = 40,
    parameter int SHIFT   = 0,
    parameter int OUT_W   = 32,
    parameter int LATENCY = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [WIDTH_A-1:0] A,
    input  logic [WIDTH_B-1:0] B,
    input  logic               SIGNED_M,
    input  logic               ACC_EN,
    input  logic               ACC_CLR,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [OUT_W-1:0]   P,
    output logic               OVF
);

    localparam int PROD_W = WIDTH_A + WIDTH_B;
    localparam int D      = LATENCY - 2;

    logic ce;

    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH_A-1:0] a_q, a_d;
    logic [WIDTH_B-1:0] b_q, b_d;
    side_t              s1_side_q, s1_side_d;

    logic [PROD_W-1:0] a_x;
    logic [PROD_W-1:0] b_x;
    (* use_dsp = "yes" *) logic [PROD_W-1:0] prod_c;

    logic              fin_valid;
    side_t             fin_side;
    logic [PROD_W-1:0] fin_prod;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] p_q, p_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] prod_x;
    logic [ACC_W-1:0] sum;
    logic             sum_ovf;
    wide_t            acc_w;
    wide_t            acc_s;
    logic [OUT_W-1:0] rs_p;
    logic             rs_clip;

    // Single global enable: the whole pipe, accumulator included, freezes together.
    assign ce        = !out_valid_q || OUT_READY;
    assign IN_READY  = ce;
    assign OUT_VALID = out_valid_q;
    assign P         = p_q;
    assign OVF       = ovf_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        s1_side_d  = s1_side_q;
        if (ce) begin
            s1_valid_d = IN_VALID;
            a_d        = A;
            b_d        = B;
            s1_side_d  = '{signed_m: SIGNED_M, acc_en: ACC_EN, acc_clr: ACC_CLR};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            s1_side_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            s1_side_q  <= s1_side_d;
        end
    end

    always_comb begin
        a_x    = PROD_W'(ext(wide_t'(a_q), WIDTH_A, s1_side_q.signed_m));
        b_x    = PROD_W'(ext(wide_t'(b_q), WIDTH_B, s1_side_q.signed_m));
        prod_c = a_x * b_x;
    end

    generate
        if (D == 0) begin : g_nodly
            assign fin_valid = s1_valid_q;
            assign fin_side  = s1_side_q;
            assign fin_prod  = prod_c;
        end else begin : g_dly
            logic [D-1:0]      v_q, v_d;
            side_t             sd_q [D];
            side_t             sd_d [D];
            logic [PROD_W-1:0] pr_q [D];
            logic [PROD_W-1:0] pr_d [D];

            always_comb begin
                v_d = v_q;
                for (int i = 0; i < D; i++) begin
                    sd_d[i] = sd_q[i];
                    pr_d[i] = pr_q[i];
                end
                if (ce) begin
                    v_d[0]  = s1_valid_q;
                    sd_d[0] = s1_side_q;
                    pr_d[0] = prod_c;
                    for (int i = 1; i < D; i++) begin
                        v_d[i]  = v_q[i-1];
                        sd_d[i] = sd_q[i-1];
                        pr_d[i] = pr_q[i-1];
                    end
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    v_q <= '0;
                    for (int i = 0; i < D; i++) begin
                        sd_q[i] <= '0;
                        pr_q[i] <= '0;
                    end
                end else begin
                    v_q <= v_d;
                    for (int i = 0; i < D; i++) begin
                        sd_q[i] <= sd_d[i];
                        pr_q[i] <= pr_d[i];
                    end
                end
            end

            assign fin_valid = v_q[D-1];
            assign fin_side  = sd_q[D-1];
            assign fin_prod  = pr_q[D-1];
        end
    endgenerate

    always_comb begin
        prod_x  = ACC_W'(ext(wide_t'(fin_prod), PROD_W, fin_side.signed_m));
        acc_w   = ext(wide_t'(acc_q), ACC_W, fin_side.signed_m)
                + ext(wide_t'(prod_x), ACC_W, fin_side.signed_m);
        if (fin_side.signed_m) begin
            acc_s = sat_signed(acc_w, ACC_W);
        end else begin
            acc_s = sat_unsigned(acc_w, ACC_W);
        end
        sum     = prod_x;
        sum_ovf = 1'b0;
        if (fin_side.acc_en && !fin_side.acc_clr) begin
            sum     = ACC_W'(acc_s);
            sum_ovf = (acc_s != acc_w);
        end
    end

    mult_pipe_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .sum      (sum),
        .signed_m (fin_side.signed_m),
        .p        (rs_p),
        .clip     (rs_clip)
    );

    always_comb begin
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        p_d         = p_q;
        ovf_d       = ovf_q;
        if (ce) begin
            out_valid_d = fin_valid;
            if (fin_valid) begin
                p_d   = rs_p;
                ovf_d = sum_ovf | rs_clip;
                if (fin_side.acc_en) begin
                    acc_d = sum;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            p_q         <= '0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            p_q         <= p_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule
